gj_axis_uart_rx_framer: RTL and testbench

- Downstream stage of the AXIS UART receiver.
- Consumes the receiver's single-cycle byte strobes (data plus error flag) and buffers them in a FIFO.
- Delimits packets by line-idle timeout and presents them as an AXI-Stream master with `tlast`, `tuser` and backpressure.
- Supplies the `rx_tlast` framing that the raw receiver does not generate.

---
 rtl/gj_axis_uart_rx_framer.sv | 93 +++++++++
 tb/tb_gj_axis_uart_rx_framer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gj_axis_uart_rx_framer.sv
// gj_axis_uart_rx_framer: frames UART RX byte strobes into AXI-Stream packets by line-idle timeout.
// Optional GJ_RX_FRAMER_OVFCNT_EN adds a saturating overflow counter port ovf_cnt.
module gj_axis_uart_rx_framer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [15:0] idle_bits,
    input  logic        in_tvalid,
    input  logic [7:0]  in_tdata,
    input  logic        in_tuser,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        overflow
`ifdef GJ_RX_FRAMER_OVFCNT_EN
    ,
    output logic [15:0] ovf_cnt
`endif
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t      state;
    logic [7:0]  st_data;
    logic        st_user;
    logic        st_vld;
    logic [15:0] cnt;
    logic        corrupt;
    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, pop, push, timeout;
    logic [9:0]  entry;
    logic [9:0]  head;

    assign st_vld = state == HOLD;

    always_comb begin
        full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
        empty   = wr_ptr == rd_ptr;
        pop     = !empty && m_tready;
        timeout = st_vld && clk_en && !in_tvalid && (cnt + 16'd1 == idle_bits);
        push    = (in_tvalid && (st_vld || idle_bits == 16'd0)) || timeout;
        // a byte arriving in IDLE is only pushed directly in the idle_bits==0 case
        entry   = (in_tvalid && !st_vld) ? {1'b1, in_tuser | corrupt, in_tdata}
                                         : {timeout, st_user | corrupt, st_data};
        head    = empty ? 10'd0 : mem[rd_ptr[AW-1:0]];
        m_tvalid = !empty;
        m_tlast  = head[9];
        m_tuser  = head[8];
        m_tdata  = head[7:0];
    end

    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            st_data  <= 8'd0;
            st_user  <= 1'b0;
            cnt      <= 16'd0;
            corrupt  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full;
            if (push) corrupt <= full;
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (in_tvalid && (st_vld || idle_bits != 16'd0)) begin
                state   <= HOLD;
                st_data <= in_tdata;
                st_user <= in_tuser;
                cnt     <= 16'd0;
            end else if (timeout) begin
                state <= IDLE;
            end else if (st_vld && clk_en) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

`ifdef GJ_RX_FRAMER_OVFCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_cnt <= 16'd0;
        else if (push && full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_gj_axis_uart_rx_framer.sv
// tb_gj_axis_uart_rx_framer: directed scoreboard bench for the RX framer with DEPTH=4.
module tb_gj_axis_uart_rx_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic [15:0] idle_bits = 16'd0;
    logic        in_tvalid = 1'b0;
    logic [7:0]  in_tdata = 8'd0;
    logic        in_tuser = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        overflow;
`ifdef GJ_RX_FRAMER_OVFCNT_EN
    logic [15:0] ovf_cnt;
`endif
    int total = 0;
    int bad = 0;
    logic [9:0] q[$];

    gj_axis_uart_rx_framer #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .idle_bits(idle_bits),
        .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_tuser(in_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .overflow(overflow)
`ifdef GJ_RX_FRAMER_OVFCNT_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic u, input logic e);
        in_tvalid = v;
        in_tdata  = d;
        in_tuser  = u;
        clk_en    = e;
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        clk_en    = 1'b0;
    endtask

    // beats accepted at the next edge are compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL beat_unexpected observed=%h expected=none", {m_tlast, m_tuser, m_tdata});
            end else begin
                chk("beat", {6'd0, m_tlast, m_tuser, m_tdata}, {6'd0, q.pop_front()});
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", {15'd0, m_tvalid}, 16'd0);
        chk("rst_payload", {6'd0, m_tlast, m_tuser, m_tdata}, 16'd0);
        chk("rst_overflow", {15'd0, overflow}, 16'd0);
`ifdef GJ_RX_FRAMER_OVFCNT_EN
        chk("rst_ovf_cnt", ovf_cnt, 16'd0);
`endif
        rst = 1'b0;
        m_tready = 1'b1;

        // timeout framing with idle_bits=3
        idle_bits = 16'd3;
        q.push_back({1'b0, 1'b0, 8'h11});
        q.push_back({1'b0, 1'b0, 8'h22});
        q.push_back({1'b1, 1'b0, 8'h33});
        step(1, 8'h11, 0, 1);
        step(1, 8'h22, 0, 1);
        step(1, 8'h33, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        chk("t1_no_early", {15'd0, m_tvalid}, 16'd0);
        step(0, 8'h00, 0, 1);
        chk("t1_tvalid3", {15'd0, m_tvalid}, 16'd1);
        chk("t1_last3", {6'd0, m_tlast, m_tuser, m_tdata}, {6'd0, 2'b10, 8'h33});
        step(0, 8'h00, 0, 0);

        // idle_bits=0: each byte is its own packet
        idle_bits = 16'd0;
        q.push_back({1'b1, 1'b0, 8'hA5});
        q.push_back({1'b1, 1'b0, 8'h5A});
        step(1, 8'hA5, 0, 0);
        chk("t2_a5", {6'd0, m_tvalid, m_tlast, m_tdata}, {6'd0, 2'b11, 8'hA5});
        step(1, 8'h5A, 0, 0);
        chk("t2_5a", {6'd0, m_tvalid, m_tlast, m_tdata}, {6'd0, 2'b11, 8'h5A});
        step(0, 8'h00, 0, 0);

        // error flag passes through per byte
        idle_bits = 16'd2;
        q.push_back({1'b0, 1'b0, 8'h01});
        q.push_back({1'b0, 1'b1, 8'h02});
        q.push_back({1'b1, 1'b0, 8'h03});
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 1, 0);
        step(1, 8'h03, 0, 0);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        // overflow with ready held low
        m_tready = 1'b0;
        q.push_back({1'b0, 1'b0, 8'h41});
        q.push_back({1'b0, 1'b0, 8'h42});
        q.push_back({1'b0, 1'b0, 8'h43});
        q.push_back({1'b0, 1'b0, 8'h44});
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h41 + 8'(i), 0, 0);
            chk("t4_no_ovf", {15'd0, overflow}, 16'd0);
        end
        step(1, 8'h46, 0, 0);
        chk("t4_ovf_pulse", {15'd0, overflow}, 16'd1);
`ifdef GJ_RX_FRAMER_OVFCNT_EN
        chk("t4_ovf_cnt", ovf_cnt, 16'd1);
`endif
        chk("t4_head", {7'd0, m_tvalid, m_tdata}, {7'd0, 1'b1, 8'h41});
        step(0, 8'h00, 0, 0);
        chk("t4_ovf_once", {15'd0, overflow}, 16'd0);
        chk("t4_hold_stable", {6'd0, m_tlast, m_tuser, m_tdata}, {6'd0, 2'b00, 8'h41});
        m_tready = 1'b1;
        repeat (4) step(0, 8'h00, 0, 0);
        chk("t4_drained", {15'd0, m_tvalid}, 16'd0);
        q.push_back({1'b1, 1'b1, 8'h46});
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        chk("t4_corrupt_user", {14'd0, m_tuser, m_tlast}, 16'd3);
        step(0, 8'h00, 0, 0);
        q.push_back({1'b1, 1'b0, 8'h99});
        step(1, 8'h99, 0, 0);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        chk("t4_corrupt_cleared", {14'd0, m_tvalid, m_tuser}, 16'd2);
        step(0, 8'h00, 0, 0);

        // byte strobe coincides with the terminal tick
        q.push_back({1'b0, 1'b0, 8'h61});
        q.push_back({1'b1, 1'b0, 8'h62});
        step(1, 8'h61, 0, 0);
        step(0, 8'h00, 0, 1);
        step(1, 8'h62, 0, 1);
        chk("t5_push_last0", {6'd0, m_tvalid, m_tlast, m_tdata}, {6'd0, 2'b10, 8'h61});
        step(0, 8'h00, 0, 1);
        chk("t5_continues", {15'd0, m_tvalid}, 16'd0);
        step(0, 8'h00, 0, 1);
        chk("t5_final", {6'd0, m_tvalid, m_tlast, m_tdata}, {6'd0, 2'b11, 8'h62});
        step(0, 8'h00, 0, 0);

        // reset in HOLD with two entries queued
        m_tready = 1'b0;
        idle_bits = 16'd3;
        step(1, 8'h71, 0, 0);
        step(1, 8'h72, 0, 0);
        step(1, 8'h73, 0, 0);
        chk("t6_queued", {15'd0, m_tvalid}, 16'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_tvalid", {15'd0, m_tvalid}, 16'd0);
        chk("t6_rst_payload", {6'd0, m_tlast, m_tuser, m_tdata}, 16'd0);
        chk("t6_rst_overflow", {15'd0, overflow}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_tready = 1'b1;
        idle_bits = 16'd1;
        q.push_back({1'b1, 1'b0, 8'h7E});
        step(1, 8'h7E, 0, 0);
        chk("t6_staged_only", {15'd0, m_tvalid}, 16'd0);
        step(0, 8'h00, 0, 1);
        chk("t6_single", {6'd0, m_tvalid, m_tlast, m_tdata}, {6'd0, 2'b11, 8'h7E});
        repeat (3) step(0, 8'h00, 0, 1);
        chk("end_idle", {15'd0, m_tvalid}, 16'd0);
        chk("sb_empty", 16'(q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
